// File: rtl/instruction_fetch.sv
// Instruction fetch: REQ -> WAIT_RSP -> HOLD -> WAIT_PC loop, sticky FAULT on a misaligned next PC.
// Latency: 2 cycles from request to instr_valid with zero wait. Backpressure: holds request/instruction stable until ready.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        pc_update,
  input  logic [31:0] next_pc,
  output logic        fetch_fault,
  output logic [31:0] fault_addr,
  output logic [31:0] fetch_count
);

  typedef enum logic [2:0] {
    S_REQ      = 3'd0,
    S_WAIT_RSP = 3'd1,
    S_HOLD     = 3'd2,
    S_WAIT_PC  = 3'd3,
    S_FAULT    = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_req_vld;
  logic        r_instr_vld;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_fault;
  logic [31:0] r_fault_addr;
  logic [31:0] r_fetch_count;

  logic w_req_acc;
  logic w_rsp_acc;
  logic w_dec_acc;
  logic w_pc_upd;
  logic w_misalign;

  // Request acceptance also requires the registered valid so nothing is accepted in the reset-release cycle.
  assign w_req_acc  = (r_state == S_REQ) && r_req_vld && imem_req_ready;
  assign w_rsp_acc  = (r_state == S_WAIT_RSP) && imem_rsp_valid;
  assign w_dec_acc  = (r_state == S_HOLD) && instr_ready;
  assign w_pc_upd   = (r_state == S_WAIT_PC) && pc_update;
  assign w_misalign = (next_pc[1:0] != 2'b00);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ:      if (w_req_acc) w_state_nxt = S_WAIT_RSP;
      S_WAIT_RSP: if (w_rsp_acc) w_state_nxt = S_HOLD;
      S_HOLD:     if (w_dec_acc) w_state_nxt = S_WAIT_PC;
      S_WAIT_PC:  if (w_pc_upd)  w_state_nxt = w_misalign ? S_FAULT : S_REQ;
      S_FAULT:    w_state_nxt = S_FAULT;
      default:    w_state_nxt = S_REQ;
    endcase
  end

  // Valids are registered from the next state so both stay low during reset and never overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_REQ;
      r_req_vld   <= 1'b0;
      r_instr_vld <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_vld   <= (w_state_nxt == S_REQ);
      r_instr_vld <= (w_state_nxt == S_HOLD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_instr       <= 32'h0;
      r_instr_pc    <= 32'h0;
      r_fault       <= 1'b0;
      r_fault_addr  <= 32'h0;
      r_fetch_count <= 32'h0;
    end else begin
      if (w_rsp_acc) begin
        r_instr    <= imem_rsp_data;
        r_instr_pc <= r_pc;
      end
      if (w_dec_acc) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (w_pc_upd) begin
        if (w_misalign) begin
          r_fault      <= 1'b1;
          r_fault_addr <= next_pc;
        end else begin
          r_pc <= next_pc;
        end
      end
    end
  end

  assign imem_req_valid = r_req_vld;
  assign imem_req_addr  = r_pc;
  assign instr_valid    = r_instr_vld;
  assign instr          = r_instr;
  assign instr_pc       = r_instr_pc;
  assign fetch_fault    = r_fault;
  assign fault_addr     = r_fault_addr;
  assign fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: scoreboarded fetch loop, stalls, ignored pulses, fault, count wrap and mid-flight reset.
module tb_instruction_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        pc_update;
  logic [31:0] next_pc;
  logic        fetch_fault;
  logic [31:0] fault_addr;
  logic [31:0] fetch_count;

  instruction_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .pc_update(pc_update), .next_pc(next_pc),
    .fetch_fault(fetch_fault), .fault_addr(fault_addr), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_addr_q[$];
  logic [63:0] sb_q[$];
  logic [31:0] exp_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Valid request and valid instruction must never be presented together.
  always @(negedge clk) begin
    if (rst_n) check("excl", 32'(imem_req_valid & instr_valid), 32'h0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1);
  end

  task automatic fetch(input logic [31:0] data, input int req_stall, input int hold_stall, input bit preload);
    logic [31:0] a0;
    logic [31:0] ea;
    logic [63:0] exp;
    int n;
    n = 0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = ~data;
    while (!imem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_vld", 32'(imem_req_valid), 32'h1);
    a0 = imem_req_addr;
    if (exp_addr_q.size() != 0) ea = exp_addr_q.pop_front();
    else ea = 32'hxxxx_xxxx;
    check("req_addr", a0, ea);
    for (int i = 0; i < req_stall; i++) begin
      imem_req_ready = 1'b0;
      @(negedge clk);
      check("req_hold_vld", 32'(imem_req_valid), 32'h1);
      check("req_hold_addr", imem_req_addr, a0);
    end
    // Response in the acceptance cycle carries junk and must be ignored.
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    check("req_single", 32'(imem_req_valid), 32'h0);
    check("no_early_vld", 32'(instr_valid), 32'h0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    sb_q.push_back({data, a0});
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hBAD0_BAD0;
    check("instr_vld", 32'(instr_valid), 32'h1);
    if (sb_q.size() != 0) exp = sb_q.pop_front();
    else exp = 64'hxxxx_xxxx_xxxx_xxxx;
    check("instr", instr, exp[63:32]);
    check("instr_pc", instr_pc, exp[31:0]);
    for (int i = 0; i < hold_stall; i++) begin
      instr_ready = 1'b0;
      pc_update   = 1'b1;
      next_pc     = 32'h0000_0080;
      imem_rsp_valid = 1'b1;
      @(negedge clk);
      pc_update   = 1'b0;
      imem_rsp_valid = 1'b0;
      check("hold_vld", 32'(instr_valid), 32'h1);
      check("hold_instr", instr, exp[63:32]);
      check("hold_pc", instr_pc, exp[31:0]);
      check("hold_count", fetch_count, exp_count);
    end
    if (preload) begin
      force dut.r_fetch_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_fetch_count;
      exp_count = 32'hFFFF_FFFF;
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    exp_count = exp_count + 32'd1;
    check("count", fetch_count, exp_count);
    check("post_vld", 32'(instr_valid), 32'h0);
    check("waitpc_req", 32'(imem_req_valid), 32'h0);
  endtask

  task automatic set_pc(input logic [31:0] v);
    pc_update = 1'b1;
    next_pc   = v;
    @(negedge clk);
    pc_update = 1'b0;
    next_pc   = 32'h0;
    if (v[1:0] == 2'b00) exp_addr_q.push_back(v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    exp_addr_q.delete();
    sb_q.delete();
    exp_count = 32'h0;
    check("rst_req_vld", 32'(imem_req_valid), 32'h0);
    check("rst_instr_vld", 32'(instr_valid), 32'h0);
    check("rst_count", fetch_count, 32'h0);
    check("rst_fault", 32'(fetch_fault), 32'h0);
    check("rst_fault_addr", fault_addr, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_addr", imem_req_addr, RST_PC);
    rst_n = 1'b1;
    exp_addr_q.push_back(RST_PC);
    @(negedge clk);
    check("rel_req_vld", 32'(imem_req_valid), 32'h1);
  endtask

  initial begin
    logic [31:0] a;
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    instr_ready    = 1'b0;
    pc_update      = 1'b0;
    next_pc        = 32'h0;
    exp_count      = 32'h0;
    repeat (2) @(negedge clk);
    do_reset();

    fetch(32'h0000_0013, 0, 0, 1'b0);
    set_pc(32'h0000_0040);
    fetch(32'h0050_0093, 3, 5, 1'b0);
    for (int k = 0; k < 6; k++) begin
      a = 32'($urandom_range(0, 1023)) << 2;
      set_pc(a);
      fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    set_pc(32'h0000_0042);
    check("fault", 32'(fetch_fault), 32'h1);
    check("fault_addr", fault_addr, 32'h0000_0042);
    for (int i = 0; i < 5; i++) begin
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b1;
      pc_update      = 1'b1;
      next_pc        = 32'h0000_0100;
      @(negedge clk);
      check("fault_req", 32'(imem_req_valid), 32'h0);
      check("fault_ivld", 32'(instr_valid), 32'h0);
      check("fault_sticky", 32'(fetch_fault), 32'h1);
      check("fault_addr_hold", fault_addr, 32'h0000_0042);
    end
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    pc_update      = 1'b0;

    do_reset();
    fetch(32'h1111_2222, 0, 1, 1'b1);
    set_pc(32'h0000_0100);
    fetch(32'h3333_4444, 1, 0, 1'b0);
    set_pc(32'h0000_0200);

    // Abandon a fetch in WAIT_RSP, then present a stale response after release.
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    check("mid_waitrsp", 32'(imem_req_valid), 32'h0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(imem_req_valid), 32'h0);
    check("mid_rst_count", fetch_count, 32'h0);
    @(negedge clk);
    exp_addr_q.delete();
    sb_q.delete();
    exp_count = 32'h0;
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    check("stale_req_vld", 32'(imem_req_valid), 32'h1);
    check("stale_addr", imem_req_addr, RST_PC);
    check("stale_ivld", 32'(instr_valid), 32'h0);
    check("stale_instr", instr, 32'h0);
    exp_addr_q.push_back(RST_PC);
    fetch(32'h5555_6666, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
